// File: rtl/jacobi_pkg.sv
// Shared constants and state encoding for the Jacobi matrix-multiply row sequencer.
package jacobi_pkg;

    localparam int unsigned N      = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned PERF_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Saturating increment for the performance cycle counter.
    function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] v);
        logic [PERF_W-1:0] r;
        r = (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/idx_delay_line.sv
// Fixed-depth register pipe that aligns the row index with row-RAM read data.
// LAT = 0 passes the input straight through.
module idx_delay_line #(
    parameter int unsigned W   = 5,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (LAT == 0) begin : g_pass
            assign dout = din;
        end else if (LAT == 1) begin : g_one
            logic [W-1:0] pipe_q;
            logic [W-1:0] pipe_d;

            always_comb begin
                pipe_d = din;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign dout = pipe_q;
        end else begin : g_multi
            logic [LAT*W-1:0] pipe_q;
            logic [LAT*W-1:0] pipe_d;

            // Newest entry in the low slice, oldest in the high slice.
            always_comb begin
                pipe_d = {pipe_q[(LAT-1)*W-1:0], din};
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign dout = pipe_q[LAT*W-1 -: W];
        end
    endgenerate

endmodule

// File: rtl/matmul_row_sequencer.sv
// Sequences one 32-row pass of the Jacobi 32x32 matrix multiplier: issues row reads,
// aligns row indices, forwards result writes and flags faults. Optional MATMUL_SEQ_PERF_EN adds perf_cycles.
module matmul_row_sequencer
    import jacobi_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bank_sel,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             ram_rd_en,
    output logic [IDX_W-1:0] ram_rd_addr,
    output logic [IDX_W-1:0] mm_index_a,
    output logic [IDX_W-1:0] mm_index_b,
    output logic             mm_select_in,
    input  logic             mm_select_out,
    input  logic             mm_write_data,
    input  logic [IDX_W-1:0] mm_out_address,
`ifdef MATMUL_SEQ_PERF_EN
    output logic [15:0]      perf_cycles,
`endif
    output logic             res_wr_en,
    output logic [IDX_W-1:0] res_wr_addr,
    output logic             res_wr_bank
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               bank_q, bank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               ram_rd_en_q, ram_rd_en_d;
    logic [IDX_W-1:0]   ram_rd_addr_q, ram_rd_addr_d;
    logic               res_wr_en_q, res_wr_en_d;
    logic [IDX_W-1:0]   res_wr_addr_q, res_wr_addr_d;
    logic               res_wr_bank_q, res_wr_bank_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic [TO_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic               collecting;
    logic               strobe_fault;
`ifdef MATMUL_SEQ_PERF_EN
    logic [PERF_W-1:0]  perf_cnt_q, perf_cnt_d;
    logic [PERF_W-1:0]  perf_cycles_q, perf_cycles_d;
`endif

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        error_d       = error_q;
        ram_rd_en_d   = 1'b0;
        ram_rd_addr_d = ram_rd_addr_q;
        res_wr_en_d   = 1'b0;
        res_wr_addr_d = res_wr_addr_q;
        res_wr_bank_d = res_wr_bank_q;
        issue_cnt_d   = issue_cnt_q;
        res_cnt_d     = res_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        strobe_fault  = 1'b0;
        collecting    = (state_q == ISSUE) || (state_q == DRAIN);
`ifdef MATMUL_SEQ_PERF_EN
        perf_cnt_d    = perf_cnt_q;
        perf_cycles_d = perf_cycles_q;
`endif

        // Result strobes: forward while a pass is active, otherwise only flag them.
        if (mm_write_data) begin
            if (collecting) begin
                res_wr_en_d   = 1'b1;
                res_wr_addr_d = mm_out_address;
                res_wr_bank_d = mm_select_out;
                if (mm_select_out != bank_q) begin
                    strobe_fault = 1'b1;
                end
                if (res_cnt_q == CNT_W'(N)) begin
                    strobe_fault = 1'b1;
                end else begin
                    if (mm_out_address != res_cnt_q[IDX_W-1:0]) begin
                        strobe_fault = 1'b1;
                    end
                    res_cnt_d = res_cnt_q + CNT_W'(1);
                end
            end else begin
                strobe_fault = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = ISSUE;
                    bank_d        = bank_sel;
                    error_d       = 1'b0;
                    ram_rd_en_d   = 1'b1;
                    ram_rd_addr_d = '0;
                    issue_cnt_d   = CNT_W'(1);
                    res_cnt_d     = '0;
                    drain_cnt_d   = '0;
`ifdef MATMUL_SEQ_PERF_EN
                    perf_cnt_d    = PERF_W'(1);
`endif
                end
            end
            ISSUE: begin
`ifdef MATMUL_SEQ_PERF_EN
                perf_cnt_d = perf_sat_inc(perf_cnt_q);
`endif
                if (issue_cnt_q == CNT_W'(N)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    ram_rd_en_d   = 1'b1;
                    ram_rd_addr_d = issue_cnt_q[IDX_W-1:0];
                    issue_cnt_d   = issue_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
`ifdef MATMUL_SEQ_PERF_EN
                perf_cnt_d = perf_sat_inc(perf_cnt_q);
`endif
                drain_cnt_d = drain_cnt_q + TO_W'(1);
                // Completion wins over a timeout landing in the same cycle.
                if (res_cnt_d == CNT_W'(N)) begin
                    state_d = DONE;
                end else if (drain_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
`ifdef MATMUL_SEQ_PERF_EN
                if (state_d == DONE) begin
                    perf_cycles_d = perf_sat_inc(perf_sat_inc(perf_cnt_q));
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (strobe_fault) begin
            error_d = 1'b1;
        end

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bank_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            res_wr_bank_q <= 1'b0;
            issue_cnt_q   <= '0;
            res_cnt_q     <= '0;
            drain_cnt_q   <= '0;
`ifdef MATMUL_SEQ_PERF_EN
            perf_cnt_q    <= '0;
            perf_cycles_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            res_wr_en_q   <= res_wr_en_d;
            res_wr_addr_q <= res_wr_addr_d;
            res_wr_bank_q <= res_wr_bank_d;
            issue_cnt_q   <= issue_cnt_d;
            res_cnt_q     <= res_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
`ifdef MATMUL_SEQ_PERF_EN
            perf_cnt_q    <= perf_cnt_d;
            perf_cycles_q <= perf_cycles_d;
`endif
        end
    end

    // Index follows the read address by the row-RAM latency so it meets the data.
    idx_delay_line #(
        .W   (IDX_W),
        .LAT (RD_LAT)
    ) u_idx_delay (
        .clk   (clk),
        .reset (reset),
        .din   (ram_rd_addr_q),
        .dout  (mm_index_a)
    );

    assign mm_index_b   = mm_index_a;
    assign mm_select_in = bank_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign ram_rd_en    = ram_rd_en_q;
    assign ram_rd_addr  = ram_rd_addr_q;
    assign res_wr_en    = res_wr_en_q;
    assign res_wr_addr  = res_wr_addr_q;
    assign res_wr_bank  = res_wr_bank_q;
`ifdef MATMUL_SEQ_PERF_EN
    assign perf_cycles  = perf_cycles_q;
`endif

endmodule

// File: tb/tb_matmul_row_sequencer.sv
// Scoreboard bench for matmul_row_sequencer with a behavioural row-RAM/multiplier model.
// Define MATMUL_SEQ_PERF_EN to also check perf_cycles.
module tb_matmul_row_sequencer;
    import jacobi_pkg::*;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned MLAT   = 3;
    localparam int unsigned DLY    = RD_LAT + MLAT;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             bank_sel = 1'b0;
    logic             busy, done, error;
    logic             ram_rd_en;
    logic [IDX_W-1:0] ram_rd_addr;
    logic [IDX_W-1:0] mm_index_a, mm_index_b;
    logic             mm_select_in;
    logic             mm_select_out = 1'b0;
    logic             mm_write_data = 1'b0;
    logic [IDX_W-1:0] mm_out_address = '0;
    logic             res_wr_en;
    logic [IDX_W-1:0] res_wr_addr;
    logic             res_wr_bank;
`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0]      perf_cycles;
`endif

    matmul_row_sequencer #(
        .RD_LAT  (RD_LAT),
        .TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bank_sel       (bank_sel),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .ram_rd_en      (ram_rd_en),
        .ram_rd_addr    (ram_rd_addr),
        .mm_index_a     (mm_index_a),
        .mm_index_b     (mm_index_b),
        .mm_select_in   (mm_select_in),
        .mm_select_out  (mm_select_out),
        .mm_write_data  (mm_write_data),
        .mm_out_address (mm_out_address),
`ifdef MATMUL_SEQ_PERF_EN
        .perf_cycles    (perf_cycles),
`endif
        .res_wr_en      (res_wr_en),
        .res_wr_addr    (res_wr_addr),
        .res_wr_bank    (res_wr_bank)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int reads  = 0;
    int writes = 0;
    int dones  = 0;
    int done_cyc = 0;
    int mdl_mode = 0;      // 0 ideal, 1 swap rows 5/6, 2 drop row 31
    logic exp_bank = 1'b0;

    typedef struct packed {
        logic [IDX_W-1:0] addr;
        logic             bank;
    } wr_t;

    wr_t              wr_q[$];
    logic [IDX_W-1:0] idx_q[$];

    logic             sv[64];
    logic [IDX_W-1:0] sa[64];
    logic             ss[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({busy, done, error, ram_rd_en, ram_rd_addr, mm_index_a, mm_index_b,
                    mm_select_in, res_wr_en, res_wr_addr, res_wr_bank});
    endfunction

    // Row RAM + multiplier model: a strobe appears DLY cycles after each read.
    always @(negedge clk) begin
        int slot;
        int ns;
        logic [IDX_W-1:0] a;
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                sv[i] = 1'b0;
                sa[i] = '0;
                ss[i] = 1'b0;
            end
            mm_write_data  = 1'b0;
            mm_out_address = '0;
            mm_select_out  = 1'b0;
        end else begin
            slot = int'(cyc % 64);
            mm_write_data  = sv[slot];
            mm_out_address = sa[slot];
            mm_select_out  = ss[slot];
            if (sv[slot]) wr_q.push_back({sa[slot], exp_bank});
            sv[slot] = 1'b0;
            if (ram_rd_en) begin
                a = ram_rd_addr;
                if (mdl_mode == 1 && a == 5'd5) a = 5'd6;
                else if (mdl_mode == 1 && a == 5'd6) a = 5'd5;
                if (!(mdl_mode == 2 && ram_rd_addr == 5'd31)) begin
                    ns = int'((cyc + DLY) % 64);
                    sv[ns] = 1'b1;
                    sa[ns] = a;
                    ss[ns] = mm_select_in;
                end
            end
        end
    end

    // Monitor: read order, index alignment, write scoreboard, done pulses.
    logic             rd_prev = 1'b0;
    logic [IDX_W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        logic [IDX_W-1:0] e;
        wr_t w;
        if (reset) begin
            wr_q.delete();
            idx_q.delete();
            rd_prev   = 1'b0;
            prev_addr = '0;
        end else begin
            if (idx_q.size() > 0) begin
                e = idx_q.pop_front();
                check("mm_index_a", 32'(mm_index_a), 32'(e));
                check("mm_index_b", 32'(mm_index_b), 32'(e));
            end
            if (ram_rd_en) begin
                check("ram_rd_addr", 32'(ram_rd_addr), rd_prev ? 32'(5'(prev_addr + 5'd1)) : 32'd0);
                idx_q.push_back(ram_rd_addr);
                prev_addr = ram_rd_addr;
                reads++;
            end
            rd_prev = ram_rd_en;
            if (res_wr_en) begin
                writes++;
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("res_wr_addr", 32'(res_wr_addr), 32'(w.addr));
                    check("res_wr_bank", 32'(res_wr_bank), 32'(w.bank));
                end
            end
            if (done) begin
                dones++;
                done_cyc = int'(cyc);
            end
            if (busy) check("mm_select_in", 32'(mm_select_in), 32'(exp_bank));
        end
    end

    task automatic run_pass(input logic b, input int mode, input bit poke, input int exp_done,
                            input logic exp_err, input int exp_wr);
        int d0, r0, w0, base, rel;
        bit seen;
        d0 = dones; r0 = reads; w0 = writes; seen = 1'b0;
        mdl_mode = mode;
        start    = 1'b1;
        bank_sel = b;
        exp_bank = b;
        base     = int'(cyc);
        tick;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("error_cleared", 32'(error), 32'd0);
        for (int i = 0; i < 200 && !seen; i++) begin
            tick;
            rel = int'(cyc) - base;
            if (poke && rel == 5) begin
                start = 1'b1;
                bank_sel = ~b;
            end else if (poke && rel == 6) begin
                start = 1'b0;
            end
            if (mode == 1 && rel == 10) check("err_before_swap", 32'(error), 32'd0);
            if (mode == 1 && rel == 11) check("err_at_swap", 32'(error), 32'd1);
            if (dones != d0) seen = 1'b1;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_cycle", 32'(done_cyc - base), 32'(exp_done));
            check("error_at_done", 32'(error), 32'(exp_err));
            check("busy_at_done", 32'(busy), 32'd0);
        end
        if (poke) begin
            start = 1'b1;
            bank_sel = ~b;
        end
        tick;
        start = 1'b0;
        repeat (3) tick;
        check("done_count", 32'(dones - d0), 32'd1);
        check("read_count", 32'(reads - r0), 32'd32);
        check("write_count", 32'(writes - w0), 32'(exp_wr));
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        bit found;
        repeat (3) tick;
        check("reset_outputs", outs_vec(), 32'd0);
        reset = 1'b0;
        tick;

        run_pass(1'b1, 0, 1'b0, 37, 1'b0, 32);
`ifdef MATMUL_SEQ_PERF_EN
        check("perf_ideal", 32'(perf_cycles), 32'd38);
`endif
        run_pass(1'b0, 0, 1'b1, 37, 1'b0, 32);
        run_pass(1'b1, 1, 1'b0, 37, 1'b1, 32);
        run_pass(1'b0, 2, 1'b0, 97, 1'b1, 31);
`ifdef MATMUL_SEQ_PERF_EN
        check("perf_timeout", 32'(perf_cycles), 32'd98);
`endif

        // Abort a pass with reset at issue count 10.
        mdl_mode = 0;
        d0 = dones;
        found = 1'b0;
        start = 1'b1;
        bank_sel = 1'b1;
        exp_bank = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ram_rd_en && ram_rd_addr == 5'd10) found = 1'b1;
            else tick;
        end
        check("reached_addr10", 32'(found), 32'd1);
        reset = 1'b1;
        tick;
        check("outputs_after_abort", outs_vec(), 32'd0);
        repeat (2) tick;
        reset = 1'b0;
        repeat (5) tick;
        check("no_done_after_abort", 32'(dones - d0), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);

        run_pass(1'b1, 0, 1'b0, 37, 1'b0, 32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
